// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : Instruction fetch front end. Owns the program counter,       |
// |               issues single-outstanding word fetches over a req/gnt/rvalid |
// |               handshake, buffers returned words in a small prefetch FIFO   |
// |               and hands {instr, instr_pc} to the decoder with valid/ready. |
// |               Redirects flush the FIFO and re-steer the PC; a response     |
// |               that belongs to the old stream is dropped on arrival.        |
// | Ports       : clk, rst_n (async, active low)                               |
// |               imem_req/imem_addr/imem_gnt   - fetch request channel        |
// |               imem_rvalid/imem_rdata        - fetch response channel       |
// |               redirect_valid/redirect_pc    - flush and restart            |
// |               instr_valid/instr_ready/instr/instr_pc - decoder interface   |
// |               perf_fetch_cnt/perf_flush_cnt - only with IFU_PERF_CNT_EN    |
// | Options     : define IFU_PERF_CNT_EN to add the performance counters.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      req_pc_q, req_pc_d;     // address of the outstanding fetch
   logic             discard_q, discard_d;   // outstanding fetch belongs to a flushed stream
   logic [31:0]      fifo_instr_q [FIFO_DEPTH];
   logic [31:0]      fifo_instr_d [FIFO_DEPTH];
   logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]      fifo_pc_d    [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             fifo_has_room;
   logic             fetch_fire;
   logic             resp_fire;
   logic             push;
   logic             pop;
   logic [31:0]      redirect_target;
   logic             unused_redirect_lsbs;

   assign redirect_target      = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Requests are only raised with a free slot, and only one can be in flight,
   // so a returning response always has somewhere to go.
   assign fifo_has_room = (count_q < DEPTH_C);
   assign fetch_fire    = imem_req && imem_gnt;
   // rvalid is only meaningful while a fetch is outstanding; after a reset it is ignored.
   assign resp_fire     = (state_q == ST_RESP) && imem_rvalid;
   assign push          = resp_fire && !discard_q && !redirect_valid;
   assign pop           = instr_valid && instr_ready && !redirect_valid;

   // ---------------------------------------------------------------- FSM state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ----------------------------------------------------------- FSM next state
   // Redirects never change the request/response sequencing: a granted fetch
   // must still be waited out, it is just marked for discard.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ:  if (fetch_fire)  state_d = ST_RESP;
         ST_RESP: if (imem_rvalid) state_d = ST_REQ;
         default: state_d = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------- FSM outputs
   always_comb begin
      imem_req  = (state_q == ST_REQ) && fifo_has_room;
      imem_addr = pc_q;
   end

   // ------------------------------------------------------ PC / discard update
   always_comb begin
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      discard_d = discard_q;
      if (fetch_fire) begin
         pc_d     = pc_q + 32'd4;
         req_pc_d = pc_q;
      end
      if (resp_fire) begin
         discard_d = 1'b0;
      end
      if (redirect_valid) begin
         pc_d = redirect_target;
         // A fetch granted this cycle, or one still awaited, is for the old stream.
         if (fetch_fire || ((state_q == ST_RESP) && !imem_rvalid)) begin
            discard_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------ prefetch FIFO
   always_comb begin
      fifo_instr_d = fifo_instr_q;
      fifo_pc_d    = fifo_pc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      if (redirect_valid) begin
         // Flush by collapsing the write pointer onto the read pointer; the
         // head outputs keep their last value while empty.
         wr_ptr_d = rd_ptr_q;
         count_d  = '0;
      end else begin
         if (push) begin
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]    = req_pc_q;
            wr_ptr_d               = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   assign instr_valid = (count_q != '0);
   assign instr       = fifo_instr_q[rd_ptr_q];
   assign instr_pc    = fifo_pc_q[rd_ptr_q];

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         req_pc_q  <= '0;
         discard_q <= 1'b0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr_q[i] <= '0;
            fifo_pc_q[i]    <= '0;
         end
      end else begin
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         discard_q    <= discard_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         fifo_instr_q <= fifo_instr_d;
         fifo_pc_q    <= fifo_pc_d;
      end
   end

   // ----------------------------------------------------- performance counters
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
   logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

   always_comb begin
      perf_fetch_cnt_d = perf_fetch_cnt_q;
      perf_flush_cnt_d = perf_flush_cnt_q;
      if (push) begin
         perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
      end
      if (redirect_valid) begin
         perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt_q <= '0;
         perf_flush_cnt_q <= '0;
      end else begin
         perf_fetch_cnt_q <= perf_fetch_cnt_d;
         perf_flush_cnt_q <= perf_flush_cnt_d;
      end
   end

   assign perf_fetch_cnt = perf_fetch_cnt_q;
   assign perf_flush_cnt = perf_flush_cnt_q;
`else
   // Counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                          |
// | Description : Self-checking bench for instr_fetch_unit. A memory model     |
// |               answers fetches with rdata = addr ^ A5A5_0000 after a        |
// |               programmable latency; a queue model of the decoder stream    |
// |               is compared against the DUT every cycle, and directed        |
// |               scenarios pin the model with literal expectations.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
   logic [31:0] exp_fetch_cnt = 32'h0;
   logic [31:0] exp_flush_cnt = 32'h0;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } entry_t;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   // memory model
   bit          gnt_en     = 1'b0;
   int          lat        = 1;
   bit          pend       = 1'b0;
   int          pend_cnt   = 0;
   logic [31:0] pend_addr  = 32'h0;
   bit          pend_taint = 1'b0;

   // decoder-stream model
   entry_t      exp_q[$];
   logic [31:0] exp_addr = RESET_PC;
   logic [31:0] gnt_log[$];
   logic [31:0] pop_pc_log[$];
   logic [31:0] pop_word_log[$];
   int          first_gnt_cyc   = -1;
   int          first_valid_cyc = -1;

   // values sampled on the falling edge, consumed at the next rising edge
   logic        s_req, s_gnt, s_rvalid, s_redirect, s_ready, s_rst_n;
   logic [31:0] s_addr, s_rpc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         s_req      = imem_req;
         s_gnt      = imem_gnt;
         s_addr     = imem_addr;
         s_rvalid   = imem_rvalid;
         s_redirect = redirect_valid;
         s_rpc      = redirect_pc;
         s_ready    = instr_ready;
         s_rst_n    = rst_n;
      end
   end

   task automatic model_step();
      bit          done;
      bit          done_taint;
      logic [31:0] done_addr;
      entry_t      e;
      done       = pend && s_rvalid;
      done_addr  = pend_addr;
      done_taint = pend_taint;
      if (pend) begin
         if (s_rvalid) begin
            pend       = 1'b0;
            pend_taint = 1'b0;
         end else if (pend_cnt > 1) begin
            pend_cnt--;
         end
      end
      if (!s_rst_n) begin
         exp_q.delete();
         exp_addr = RESET_PC;
         if (pend) pend_taint = 1'b1;
`ifdef IFU_PERF_CNT_EN
         exp_fetch_cnt = 32'h0;
         exp_flush_cnt = 32'h0;
`endif
         return;
      end
      if (s_req && s_gnt) begin
         check("single_outstanding", {31'b0, pend}, 32'd0);
         check("fetch_addr", s_addr, exp_addr);
         gnt_log.push_back(s_addr);
         if (first_gnt_cyc < 0) first_gnt_cyc = cyc - 1;
         pend       = 1'b1;
         pend_cnt   = lat;
         pend_addr  = s_addr;
         pend_taint = s_redirect;
         exp_addr   = exp_addr + 32'd4;
      end
      if (s_redirect) begin
         exp_q.delete();
         exp_addr = {s_rpc[31:2], 2'b00};
         if (pend) pend_taint = 1'b1;
`ifdef IFU_PERF_CNT_EN
         exp_flush_cnt = exp_flush_cnt + 32'd1;
`endif
      end else begin
         if (exp_q.size() != 0 && s_ready) begin
            e = exp_q.pop_front();
            pop_pc_log.push_back(e.pc);
            pop_word_log.push_back(e.word);
         end
         if (done && !done_taint) begin
            e.pc   = done_addr;
            e.word = done_addr ^ XOR_KEY;
            exp_q.push_back(e);
`ifdef IFU_PERF_CNT_EN
            exp_fetch_cnt = exp_fetch_cnt + 32'd1;
`endif
         end
      end
   endtask

   task automatic compare_outputs();
      check("instr_valid", {31'b0, instr_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
      if (exp_q.size() != 0) begin
         check("instr", instr, exp_q[0].word);
         check("instr_pc", instr_pc, exp_q[0].pc);
      end
      if (exp_q.size() >= DEPTH) check("req_while_full", {31'b0, imem_req}, 32'd0);
      check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
`ifdef IFU_PERF_CNT_EN
      check("perf_fetch_cnt", perf_fetch_cnt, exp_fetch_cnt);
      check("perf_flush_cnt", perf_flush_cnt, exp_flush_cnt);
`endif
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         model_step();
         #1;
         compare_outputs();
         imem_gnt    = gnt_en;
         imem_rvalid = pend && (pend_cnt <= 1);
         imem_rdata  = imem_rvalid ? (pend_addr ^ XOR_KEY) : 32'hDEAD_BEEF;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          t;
      int          g;
      int          n;
      logic [31:0] last;
      int          lat_tab [3];
      logic [15:0] rdy_pat;
      lat_tab = '{1, 2, 3};
      rdy_pat = 16'b1011_0010_1110_0101;

      // ---------------- reset values
      repeat (3) tick();
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check("rst_imem_addr", imem_addr, RESET_PC);
      check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);

      // ---------------- 1: streaming fetch, ready always high
      gnt_en = 1'b1; lat = 1; instr_ready = 1'b1;
      rst_n  = 1'b1;
      t = 0;
      while (pop_pc_log.size() < 4 && t < 60) begin tick(); t++; end
      check("t1_done", (pop_pc_log.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
      if (pop_pc_log.size() >= 4) begin
         check("t1_pc0", pop_pc_log[0], 32'h0000_0000);
         check("t1_pc1", pop_pc_log[1], 32'h0000_0004);
         check("t1_pc2", pop_pc_log[2], 32'h0000_0008);
         check("t1_pc3", pop_pc_log[3], 32'h0000_000C);
         check("t1_word0", pop_word_log[0], 32'hA5A5_0000);
         check("t1_word3", pop_word_log[3], 32'hA5A5_000C);
      end
      check("t1_first_valid_latency", first_valid_cyc - first_gnt_cyc, 32'd2);

      // ---------------- 2: decoder stall fills the FIFO
      instr_ready = 1'b0;
      repeat (10) tick();
      check("t2_req_low_full", {31'b0, imem_req}, 32'd0);
      check("t2_valid_held", {31'b0, instr_valid}, 32'd1);
      check("t2_model_entries", exp_q.size(), DEPTH);
      n    = pop_pc_log.size();
      last = pop_pc_log[n-1];
      instr_ready = 1'b1;
      t = 0;
      while (pop_pc_log.size() < n + 4 && t < 60) begin tick(); t++; end
      check("t2_done", (pop_pc_log.size() >= n + 4) ? 32'd1 : 32'd0, 32'd1);
      if (pop_pc_log.size() >= n + 4) begin
         for (int k = 0; k < 4; k++) begin
            check("t2_no_gap", pop_pc_log[n+k], last + 32'(4 * (k + 1)));
         end
      end

      // ---------------- 3: redirect while a response is outstanding
      lat = 3;
      t = 0;
      while (pend && t < 20) begin tick(); t++; end
      while (!pend && t < 40) begin tick(); t++; end
      check("t3_in_resp", {31'b0, pend}, 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      g = gnt_log.size();
      tick();
      redirect_valid = 1'b0;
      n = pop_pc_log.size();
      t = 0;
      while ((gnt_log.size() <= g || pop_pc_log.size() <= n) && t < 60) begin tick(); t++; end
      check("t3_done", (gnt_log.size() > g && pop_pc_log.size() > n) ? 32'd1 : 32'd0, 32'd1);
      if (gnt_log.size() > g)    check("t3_next_addr", gnt_log[g], 32'h0000_0100);
      if (pop_pc_log.size() > n) check("t3_next_pc", pop_pc_log[n], 32'h0000_0100);

      // ---------------- 4: redirect in the same cycle as the grant for 0x20
      lat = 1;
      t = 0;
      while (pend && t < 20) begin tick(); t++; end
      gnt_en = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
      tick();
      redirect_valid = 1'b0;
      t = 0;
      while (!(imem_req && imem_addr == 32'h0000_0020) && t < 40) begin tick(); t++; end
      check("t4_req_0x20", {31'b0, imem_req}, 32'd1);
      gnt_en = 1'b1;
      tick();
      g = gnt_log.size();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      tick();
      redirect_valid = 1'b0;
      n = pop_pc_log.size();
      check("t4_granted", (gnt_log.size() > g) ? 32'd1 : 32'd0, 32'd1);
      if (gnt_log.size() > g) check("t4_grant_old_pc", gnt_log[g], 32'h0000_0020);
      t = 0;
      while ((gnt_log.size() <= g + 1 || pop_pc_log.size() <= n) && t < 60) begin tick(); t++; end
      if (gnt_log.size() > g + 1) check("t4_resume_addr", gnt_log[g+1], 32'h0000_0040);
      else check("t4_resume_addr_seen", 32'd0, 32'd1);
      if (pop_pc_log.size() > n) check("t4_first_pc", pop_pc_log[n], 32'h0000_0040);
      else check("t4_first_pc_seen", 32'd0, 32'd1);

      // ---------------- 5: PC wraps past FFFF_FFFC
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      g = gnt_log.size();
      n = pop_pc_log.size();
      t = 0;
      while ((gnt_log.size() < g + 3 || pop_pc_log.size() < n + 3) && t < 60) begin tick(); t++; end
      check("t5_done", (gnt_log.size() >= g + 3 && pop_pc_log.size() >= n + 3) ? 32'd1 : 32'd0, 32'd1);
      if (gnt_log.size() >= g + 3) begin
         check("t5_addr_fff8", gnt_log[g],   32'hFFFF_FFF8);
         check("t5_addr_fffc", gnt_log[g+1], 32'hFFFF_FFFC);
         check("t5_addr_wrap", gnt_log[g+2], 32'h0000_0000);
      end
      if (pop_pc_log.size() >= n + 3) begin
         check("t5_pc_fffc",   pop_pc_log[n+1],   32'hFFFF_FFFC);
         check("t5_word_fffc", pop_word_log[n+1], 32'h5A5A_FFFC);
         check("t5_pc_wrap",   pop_pc_log[n+2],   32'h0000_0000);
         check("t5_word_wrap", pop_word_log[n+2], 32'hA5A5_0000);
      end

      // ---------------- 6: reset pulse while a response is outstanding
      lat = 6;
      t = 0;
      while (pend && t < 20) begin tick(); t++; end
      while (!pend && t < 40) begin tick(); t++; end
      check("t6_in_resp", {31'b0, pend}, 32'd1);
      rst_n = 1'b0; gnt_en = 1'b0;
      tick();
      rst_n = 1'b1;
`ifdef IFU_PERF_CNT_EN
      check("t6_perf_fetch_zero", perf_fetch_cnt, 32'd0);
      check("t6_perf_flush_zero", perf_flush_cnt, 32'd0);
`endif
      t = 0;
      while (pend && t < 20) begin tick(); t++; end
      tick();
      check("t6_stale_ignored", {31'b0, instr_valid}, 32'd0);
      g = gnt_log.size();
      n = pop_pc_log.size();
      lat = 2;
      gnt_en = 1'b1;
      t = 0;
      while ((gnt_log.size() <= g || pop_pc_log.size() <= n) && t < 60) begin tick(); t++; end
      if (gnt_log.size() > g) check("t6_first_fetch", gnt_log[g], RESET_PC);
      else check("t6_first_fetch_seen", 32'd0, 32'd1);
      if (pop_pc_log.size() > n) check("t6_first_pc", pop_pc_log[n], RESET_PC);
      else check("t6_first_pc_seen", 32'd0, 32'd1);

      // ---------------- 7: mixed latency / ready pattern with redirects
      for (int i = 0; i < 120; i++) begin
         instr_ready = rdy_pat[i % 16];
         lat         = lat_tab[i % 3];
         redirect_valid = 1'b0;
         if (i == 40) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; end
         if (i == 41) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0302; end
         if (i == 80) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_1000; end
         tick();
      end
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the instruction decoder.
- Owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned words in a small prefetch FIFO.
- Presents instruction words plus their PC to the decoder with a valid/ready handshake.
- Flushes and re-steers on branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- FIFO_DEPTH, 2, prefetch buffer entries; power of two, 2..8.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch byte address, bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid for the oldest granted request.
- imem_rdata  in  32  fetched instruction word.
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
- instr_valid  out  1  instr/instr_pc hold a valid entry.
- instr_ready  in  1  decoder accepts the entry this cycle.
- instr  out  32  instruction word to decoder.
- instr_pc  out  32  byte address of instr.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). While rst_n=0:
  - pc=RESET_PC, FIFO empty, state=IDLE, discard flag=0.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Outstanding requests: at most 1 at any time.
- Request condition: imem_req=1 only in REQ, and only when fifo_count < FIFO_DEPTH. This guarantees the FIFO never overflows.
- State machine:
  - IDLE: entered only from reset; unconditionally -> REQ next cycle.
  - REQ: drive imem_addr=pc. On imem_req&&imem_gnt: pc<=pc+4 (32-bit wrap, FFFF_FFFC -> 0000_0000), -> RESP. imem_req/imem_addr stay stable until granted.
  - RESP: imem_req=0. On imem_rvalid: if discard=0, push {pc_of_request, imem_rdata}; clear discard; -> REQ. The response can be pushed the same cycle it arrives even with a pop, as long as fifo_count < FIFO_DEPTH.
- Latency: gnt in cycle N, rvalid earliest N+1. The FIFO push happens at the rvalid edge, so instr_valid is high in N+2 when the FIFO was empty. There is no combinational path from imem_rdata to instr.
- Decoder handshake:
  - instr_valid = FIFO not empty; instr/instr_pc = FIFO head.
  - Pop on instr_valid&&instr_ready.
  - Head is stable while instr_valid=1 and instr_ready=0.
  - Simultaneous push and pop: count unchanged, order preserved.
- Redirect (redirect_valid=1), highest priority:
  - FIFO flushed; instr_valid=0 next cycle; any same-cycle pop has no effect.
  - pc <= {redirect_pc[31:2],2'b00}.
  - In REQ without gnt: stay REQ; the new address is presented next cycle.
  - In REQ with gnt the same cycle: the grant was for the old pc. Set discard=1, -> RESP.
  - In RESP without rvalid: set discard=1; that response is dropped on arrival.
  - In RESP with rvalid the same cycle: drop the word, -> REQ with the new pc.
  - Back-to-back redirects: the last one wins; discard stays set until the single outstanding response returns.
- FIFO empty: instr_valid=0; instr/instr_pc hold their last values (don't-care to the decoder).
- FIFO full: fetching stops until a pop frees an entry.
- Reset asserted mid-transaction: all state cleared immediately. Any later rvalid arriving in IDLE or REQ is ignored.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_fetch_cnt (32, out): increments on every non-discarded FIFO push.
  - perf_flush_cnt (32, out): increments on every redirect_valid cycle.
  - Both reset to 0, wrap at 2^32, and are unaffected by the FIFO-full condition.
- When undefined: neither port nor any counter logic exists. Functional behaviour is otherwise identical.

Test Plan:
- Reset release with RESET_PC=0, gnt always 1, rvalid one cycle after gnt, rdata=addr^32'hA5A5_0000, instr_ready=1 -> decoder sees pc 0,4,8,C in order with matching rdata; first instr_valid 2 cycles after first gnt.
- instr_ready=0 for 10 cycles with FIFO_DEPTH=2 -> exactly 2 entries buffered, imem_req=0 while full, no drop or overwrite; on release, pcs continue without a gap.
- Redirect to 32'h0000_0103 while in RESP -> the outstanding response is discarded; next imem_addr=0000_0100; the next decoded instr_pc is 0000_0100.
- Redirect in the same cycle as imem_gnt for pc=0x20 -> the 0x20 response is dropped; no instr_pc=0x20 emitted; fetch resumes at the target.
- pc=FFFF_FFFC granted -> next imem_addr=0000_0000.
- rst_n pulsed low in RESP, rvalid arriving after release -> ignored; first fetch at RESET_PC; instr_valid=0 until that response arrives. With IFU_PERF_CNT_EN defined, perf_fetch_cnt=0 after the reset.
